// File: rtl/pwm_commit_ctrl.sv
// Commit controller: buffers received channel words in a shadow bank and copies
// complete frames to the active PWM outputs on a period boundary.
module pwm_commit_ctrl #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter bit          COMMIT_SYNC    = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             activity,
   input  logic             frame_end,
   input  logic             period_start,
   input  logic             status_clear,
   output logic [WIDTH-1:0] v0,
   output logic [WIDTH-1:0] v1,
   output logic [WIDTH-1:0] v2,
   output logic [WIDTH-1:0] v3,
   output logic [WIDTH-1:0] v4,
   output logic [WIDTH-1:0] v5,
   output logic [WIDTH-1:0] v6,
   output logic [WIDTH-1:0] v7,
   output logic             committed,
   output logic             rx_resync,
   output logic             pending,
   output logic             timeout_flag,
   output logic             overrun_flag
);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      PEND
   } state_t;

   // Abort is decided on the cycle whose idle step would bring the timer to TIMEOUT_CYCLES-1,
   // so the registered rx_resync lands exactly TIMEOUT_CYCLES after the last event.
   localparam logic [16:0] TIMER_LAST = 17'(TIMEOUT_CYCLES - 2);
   localparam logic [16:0] TIMER_MAX  = '1;

   state_t           state;
   state_t           state_next;
   logic [16:0]      timer;
   logic [16:0]      timer_next;
   logic [WIDTH-1:0] shadow [8];
   logic [WIDTH-1:0] active [8];

   logic             quiet;
   logic             do_write;
   logic             do_commit;
   logic             do_abort;
   logic             set_overrun;

   assign quiet = !(wr_en || activity);

   always_comb begin
      state_next  = state;
      timer_next  = timer;
      do_write    = 1'b0;
      do_commit   = 1'b0;
      do_abort    = 1'b0;
      set_overrun = 1'b0;
      case (state)
         IDLE: begin
            do_write   = wr_en;
            timer_next = '0;
            if (frame_end) begin
               state_next = PEND;
            end else if (!quiet) begin
               state_next = RECV;
            end
         end
         RECV: begin
            do_write = wr_en;
            if (frame_end) begin
               state_next = PEND;
               timer_next = '0;
            end else if (!quiet) begin
               timer_next = '0;
            end else if (timer == TIMER_LAST) begin
               do_abort   = 1'b1;
               state_next = IDLE;
               timer_next = '0;
            end else if (timer != TIMER_MAX) begin
               timer_next = timer + 17'd1;
            end
         end
         PEND: begin
            timer_next  = '0;
            set_overrun = wr_en;
            // Without period alignment PEND lasts exactly one cycle.
            if (period_start || !COMMIT_SYNC) begin
               do_commit  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 8; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         committed    <= 1'b0;
         rx_resync    <= 1'b0;
         pending      <= 1'b0;
         timeout_flag <= 1'b0;
         overrun_flag <= 1'b0;
      end else begin
         committed <= do_commit;
         rx_resync <= do_abort;
         pending   <= (state_next == PEND);

         if (do_write) begin
            shadow[wr_addr] <= wr_data;
         end else if (do_abort) begin
            for (int unsigned i = 0; i < 8; i++) begin
               shadow[i] <= active[i];
            end
         end

         if (do_commit) begin
            for (int unsigned i = 0; i < 8; i++) begin
               active[i] <= shadow[i];
            end
         end

         timeout_flag <= do_abort | (timeout_flag & ~status_clear);
         overrun_flag <= set_overrun | (overrun_flag & ~status_clear);
      end
   end

   assign v0 = active[0];
   assign v1 = active[1];
   assign v2 = active[2];
   assign v3 = active[3];
   assign v4 = active[4];
   assign v5 = active[5];
   assign v6 = active[6];
   assign v7 = active[7];

endmodule

// File: tb/tb_pwm_commit_ctrl.sv
// Bench for pwm_commit_ctrl: period-aligned instance plus an immediate-commit instance,
// commit values checked against a scoreboard queue.
module tb_pwm_commit_ctrl;

   localparam int W = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [2:0]    wr_addr;
   logic [W-1:0]  wr_data;
   logic          activity;
   logic          frame_end;
   logic          period_start;
   logic          status_clear;

   logic [W-1:0]  s_v [8];
   logic          s_committed, s_rx_resync, s_pending, s_timeout_flag, s_overrun_flag;
   logic [W-1:0]  n_v [8];
   logic          n_committed, n_rx_resync, n_pending, n_timeout_flag, n_overrun_flag;

   logic [W-1:0]  m_shadow [8];
   logic [W-1:0]  m_active [8];
   logic          m_pend;
   logic [127:0]  q1 [$];
   logic [127:0]  q0 [$];
   logic          f_phase;
   int            n_checks = 0;
   int            n_fail   = 0;

   always #5 clock = ~clock;

   pwm_commit_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(16), .COMMIT_SYNC(1'b1)) dut_sync (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .activity(activity), .frame_end(frame_end), .period_start(period_start),
      .status_clear(status_clear),
      .v0(s_v[0]), .v1(s_v[1]), .v2(s_v[2]), .v3(s_v[3]),
      .v4(s_v[4]), .v5(s_v[5]), .v6(s_v[6]), .v7(s_v[7]),
      .committed(s_committed), .rx_resync(s_rx_resync), .pending(s_pending),
      .timeout_flag(s_timeout_flag), .overrun_flag(s_overrun_flag)
   );

   pwm_commit_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(16), .COMMIT_SYNC(1'b0)) dut_now (
      .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .activity(activity), .frame_end(frame_end), .period_start(period_start),
      .status_clear(status_clear),
      .v0(n_v[0]), .v1(n_v[1]), .v2(n_v[2]), .v3(n_v[3]),
      .v4(n_v[4]), .v5(n_v[5]), .v6(n_v[6]), .v7(n_v[7]),
      .committed(n_committed), .rx_resync(n_rx_resync), .pending(n_pending),
      .timeout_flag(n_timeout_flag), .overrun_flag(n_overrun_flag)
   );

   function automatic logic [127:0] pack(input logic [W-1:0] x [8]);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[i*W +: W] = x[i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) begin
         m_shadow[i] = '0;
         m_active[i] = '0;
      end
      m_pend = 1'b0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      clear_model();
      tick();
   endtask

   task automatic do_write(input logic [2:0] a, input logic [W-1:0] d, input bit fe);
      wr_en = 1'b1; wr_addr = a; wr_data = d; frame_end = fe;
      if (!m_pend) m_shadow[a] = d;
      if (fe) m_pend = 1'b1;
      tick();
      wr_en = 1'b0; frame_end = 1'b0;
   endtask

   task automatic frame_end_only();
      frame_end = 1'b1;
      m_pend = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   task automatic period(input bit with_fe);
      period_start = 1'b1; frame_end = with_fe;
      if (m_pend && !with_fe) begin
         m_active = m_shadow;
         q1.push_back(pack(m_shadow));
         m_pend = 1'b0;
      end else if (with_fe) begin
         m_pend = 1'b1;
      end
      tick();
      period_start = 1'b0; frame_end = 1'b0;
   endtask

   // Every commit pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (!reset) begin
         if (s_committed) begin
            check("s_commit_queued", 128'(q1.size() != 0), 128'(1'b1));
            if (q1.size() != 0) check("s_commit_value", pack(s_v), q1.pop_front());
         end
         if (f_phase && n_committed) begin
            check("n_commit_queued", 128'(q0.size() != 0), 128'(1'b1));
            if (q0.size() != 0) check("n_commit_value", pack(n_v), q0.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] e;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; activity = 1'b0;
      frame_end = 1'b0; period_start = 1'b0; status_clear = 1'b0; f_phase = 1'b0;
      clear_model();
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clock);
      check("rst_v", pack(s_v), '0);
      check("rst_outs", 128'({s_committed, s_rx_resync, s_pending, s_timeout_flag, s_overrun_flag}), '0);
      tick();

      // full frame, commit aligned to period_start
      for (int k = 0; k < 8; k++) do_write(3'(k), 16'(16'h1000 + k), 1'b0);
      frame_end_only();
      repeat (20) begin
         @(negedge clock);
         check("a_pending", 128'(s_pending), 128'(1'b1));
         check("a_hold", pack(s_v), '0);
         tick();
      end
      period(1'b0);
      @(negedge clock);
      check("a_committed", 128'(s_committed), 128'(1'b1));
      check("a_values", pack(s_v), {16'h1007, 16'h1006, 16'h1005, 16'h1004,
                                    16'h1003, 16'h1002, 16'h1001, 16'h1000});
      check("a_pending_fall", 128'(s_pending), '0);
      tick();
      @(negedge clock);
      check("a_commit_once", 128'(s_committed), '0);
      tick();

      // timeout after a truncated frame
      reset_dut();
      do_write(3'd0, 16'h1111, 1'b0);
      do_write(3'd1, 16'h2222, 1'b0);
      do_write(3'd2, 16'h3333, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clock);
         check("b_resync", 128'(s_rx_resync), 128'(i == 16));
         tick();
      end
      m_shadow = m_active;
      @(negedge clock);
      check("b_resync_pulse", 128'(s_rx_resync), '0);
      check("b_timeout_flag", 128'(s_timeout_flag), 128'(1'b1));
      check("b_v_zero", pack(s_v), '0);
      tick();
      frame_end_only();
      period(1'b0);
      @(negedge clock);
      check("b_discard_commit", 128'(s_committed), 128'(1'b1));
      tick();
      for (int k = 0; k < 8; k++) do_write(3'(k), 16'hABCD, k == 7);
      period(1'b0);
      @(negedge clock);
      check("b_abcd", pack(s_v), {8{16'hABCD}});
      tick();

      // overrun in PEND, status_clear colliding with a set
      do_write(3'd2, 16'h2222, 1'b1);
      status_clear = 1'b1;
      do_write(3'd2, 16'hFFFF, 1'b0);
      status_clear = 1'b0;
      @(negedge clock);
      check("c_overrun_set_wins", 128'(s_overrun_flag), 128'(1'b1));
      check("c_timeout_cleared", 128'(s_timeout_flag), '0);
      check("c_pending", 128'(s_pending), 128'(1'b1));
      tick();
      period(1'b0);
      @(negedge clock);
      check("c_v2", 128'(s_v[2]), 128'(16'h2222));
      tick();
      status_clear = 1'b1;
      tick();
      status_clear = 1'b0;
      @(negedge clock);
      check("c_overrun_clear", 128'(s_overrun_flag), '0);
      tick();

      // coincidences
      for (int k = 0; k < 4; k++) do_write(3'(k), 16'(16'h4000 + k), 1'b0);
      period(1'b1);
      @(negedge clock);
      check("d_no_commit", 128'(s_committed), '0);
      check("d_pending", 128'(s_pending), 128'(1'b1));
      tick();
      period(1'b0);
      @(negedge clock);
      check("d_late_commit", 128'(s_committed), 128'(1'b1));
      tick();
      do_write(3'd5, 16'h5555, 1'b0);
      repeat (14) tick();
      frame_end_only();
      @(negedge clock);
      check("d_no_resync", 128'(s_rx_resync), '0);
      check("d_expiry_pending", 128'(s_pending), 128'(1'b1));
      check("d_no_tflag", 128'(s_timeout_flag), '0);
      tick();
      @(negedge clock);
      check("d_no_resync_late", 128'(s_rx_resync), '0);
      tick();
      period(1'b0);
      @(negedge clock);
      check("d_v5", 128'(s_v[5]), 128'(16'h5555));
      tick();

      // reset mid-frame
      for (int k = 0; k < 4; k++) do_write(3'(k), 16'(16'h7700 + k), 1'b0);
      reset_dut();
      period(1'b0);
      @(negedge clock);
      check("e_no_commit", 128'(s_committed), '0);
      check("e_v_zero", pack(s_v), '0);
      check("e_outs", 128'({s_rx_resync, s_pending, s_timeout_flag, s_overrun_flag}), '0);
      tick();

      // immediate-commit instance
      reset_dut();
      f_phase = 1'b1;
      e = '0;
      for (int k = 0; k < 8; k++) begin
         e[k*W +: W] = 16'(16'h5A00 + k);
         do_write(3'(k), 16'(16'h5A00 + k), k == 7);
      end
      q0.push_back(e);
      @(negedge clock);
      check("f_not_yet", 128'(n_committed), '0);
      check("f_pending", 128'(n_pending), 128'(1'b1));
      tick();
      @(negedge clock);
      check("f_commit_n2", 128'(n_committed), 128'(1'b1));
      check("f_pending_fall", 128'(n_pending), '0);
      tick();
      do_write(3'd0, 16'h0BAD, 1'b1);
      e[0 +: W] = 16'h0BAD;
      q0.push_back(e);
      do_write(3'd1, 16'hFFFF, 1'b0);
      tick();
      activity = 1'b1;
      tick();
      activity = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clock);
         check("f_resync", 128'(n_rx_resync), 128'(i == 16));
         tick();
      end
      @(negedge clock);
      check("f_tflag", 128'(n_timeout_flag), 128'(1'b1));
      check("f_oflag", 128'(n_overrun_flag), 128'(1'b1));
      check("f_v_kept", pack(n_v), e);
      tick();
      status_clear = 1'b1;
      tick();
      status_clear = 1'b0;
      @(negedge clock);
      check("f_flags_clear", 128'({n_timeout_flag, n_overrun_flag}), '0);
      tick();

      check("q1_drained", 128'(q1.size()), '0);
      check("q0_drained", 128'(q0.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
